// File: rtl/riscv_fmt_pkg.sv
// Shared RISC-V format codes, opcodes, scanner FSM encoding and the decoded-record type.
// Imported by the field decoder and the instruction scanner.
package riscv_fmt_pkg;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_SB  = 3'd3;
  localparam logic [2:0] FMT_UJ  = 3'd4;
  localparam logic [2:0] FMT_U   = 3'd5;
  localparam logic [2:0] FMT_UNK = 3'd7;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_OUT   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    case (op)
      OP_REG:                   return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_SB;
      OP_JAL:                   return FMT_UJ;
      OP_LUI, OP_AUIPC:         return FMT_U;
      default:                  return FMT_UNK;
    endcase
  endfunction

endpackage

// File: rtl/rv_field_decode.sv
// Combinational RISC-V word decoder: format class, raw fields and sign-extended immediate.
// Field slices are unconditional; only the immediate depends on the format.
module rv_field_decode
  import riscv_fmt_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [2:0] fmt;
  assign fmt = fmt_of(instr[6:0]);

  always_comb begin
    // NOTE: every field gets a value on every path, so no latch can be inferred.
    dec        = '0;
    dec.fmt    = fmt;
    dec.opcode = instr[6:0];
    dec.rd     = instr[11:7];
    dec.funct3 = instr[14:12];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct7 = instr[31:25];
    case (fmt)
      FMT_I:   dec.imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_SB:  dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_UJ:  dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   dec.imm = {instr[31:12], 12'b0};
      default: dec.imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_scan_decoder.sv
// Instruction-memory scanner: fetches count words from start_addr (stride 4), decodes each
// one and presents it as a registered record on a valid/ready stream.
module inst_scan_decoder
  import riscv_fmt_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic [2:0]        out_type,
  output logic [6:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [6:0]        out_funct7,
  output logic [31:0]       out_imm,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  unk_count
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        lat_cnt;
  dec_t              dec;
  dec_t              out_dec;
  logic              latch;

  rv_field_decode u_decode (
    .instr (mem_data),
    .dec   (dec)
  );

  assign mem_addr = pc;
  assign mem_read = (state == ST_FETCH);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // Data is captured MEM_LAT cycles after the read strobe: in FETCH itself for a zero-latency mem.
  assign latch = ((state == ST_FETCH) && (LAT == 2'd0)) ||
                 ((state == ST_WAIT)  && (lat_cnt == LAT));

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, so a mid-scan reset leaves no stale record.
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      unk_count <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_dec   <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            pc        <= start_addr & ~ADDR_W'(3);
            remaining <= count;
            unk_count <= '0;
            state     <= (count != '0) ? ST_FETCH : ST_DONE;
          end
        end
        ST_FETCH: begin
          lat_cnt <= 2'd1;
          state   <= (LAT == 2'd0) ? ST_OUT : ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT) state <= ST_OUT;
          else                lat_cnt <= lat_cnt + 2'd1;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc + ADDR_W'(4);
            remaining <= remaining - CNT_W'(1);
            state     <= (remaining == CNT_W'(1)) ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (latch) begin
        out_valid <= 1'b1;
        out_pc    <= pc;
        out_instr <= mem_data;
        out_dec   <= dec;
        if ((dec.fmt == FMT_UNK) && (unk_count != '1)) unk_count <= unk_count + CNT_W'(1);
      end
    end
  end

  assign out_type   = out_dec.fmt;
  assign out_opcode = out_dec.opcode;
  assign out_rd     = out_dec.rd;
  assign out_funct3 = out_dec.funct3;
  assign out_rs1    = out_dec.rs1;
  assign out_rs2    = out_dec.rs2;
  assign out_funct7 = out_dec.funct7;
  assign out_imm    = out_dec.imm;

endmodule

// File: tb/tb_inst_scan_decoder.sv
// Self-checking bench for inst_scan_decoder: directed scans plus random images and backpressure,
// checked against an arithmetic reference decoder built from the RISC-V format rules.
module tb_inst_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [7:0]  count = '0;
  logic        abort = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_instr, out_imm;
  logic [2:0]  out_type, out_funct3;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        busy, done;
  logic [7:0]  unk_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_img [64];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } rec_t;

  inst_scan_decoder #(.ADDR_W(32), .CNT_W(8), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_type(out_type), .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm),
    .busy(busy), .done(done), .unk_count(unk_count)
  );

  always #5 clk = ~clk;

  // One-cycle registered memory, matching MEM_LAT=1.
  always @(posedge clk) if (mem_read) mem_data <= mem_img[mem_addr[7:2]];

  function automatic int fmt_model(input longint w);
    case (w % 128)
      'h33:             return 0;
      'h03, 'h13, 'h67: return 1;
      'h23:             return 2;
      'h63:             return 3;
      'h6F:             return 4;
      'h37, 'h17:       return 5;
      default:          return 7;
    endcase
  endfunction

  function automatic longint bits(input longint w, input int lo, input int n);
    return (w >> lo) % (64'sd1 << n);
  endfunction

  function automatic longint sx(input longint v, input int n);
    return (v >= (64'sd1 << (n - 1))) ? v - (64'sd1 << n) : v;
  endfunction

  function automatic logic [31:0] imm_model(input longint w);
    longint v;
    case (fmt_model(w))
      1: v = sx(bits(w, 20, 12), 12);
      2: v = sx(bits(w, 25, 7) * 32 + bits(w, 7, 5), 12);
      3: v = sx(bits(w, 31, 1) * 4096 + bits(w, 7, 1) * 2048 + bits(w, 25, 6) * 32 + bits(w, 8, 4) * 2, 13);
      4: v = sx(bits(w, 31, 1) * (64'sd1 << 20) + bits(w, 12, 8) * 4096 + bits(w, 20, 1) * 2048
                + bits(w, 21, 10) * 2, 21);
      5: v = bits(w, 12, 20) * 4096;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_record(input string tag, input rec_t r);
    longint w = longint'(r.w);
    check({tag, "_pc"},     out_pc,    r.pc);
    check({tag, "_instr"},  out_instr, r.w);
    check({tag, "_type"},   32'(out_type),   32'(fmt_model(w)));
    check({tag, "_imm"},    out_imm,   imm_model(w));
    check({tag, "_opcode"}, 32'(out_opcode), 32'(bits(w, 0, 7)));
    check({tag, "_rd"},     32'(out_rd),     32'(bits(w, 7, 5)));
    check({tag, "_funct3"}, 32'(out_funct3), 32'(bits(w, 12, 3)));
    check({tag, "_rs1"},    32'(out_rs1),    32'(bits(w, 15, 5)));
    check({tag, "_rs2"},    32'(out_rs2),    32'(bits(w, 20, 5)));
    check({tag, "_funct7"}, 32'(out_funct7), 32'(bits(w, 25, 7)));
  endtask

  task automatic pulse_start(input logic [31:0] addr, input int cnt);
    @(negedge clk);
    start = 1'b1; start_addr = addr; count = 8'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full scan with handshake checking; hold>0 stalls the first record for that many cycles.
  task automatic run_scan(input string tag, input logic [31:0] addr, input int cnt,
                          input bit rand_ready, input int hold);
    rec_t q[$];
    rec_t r;
    int got = 0, done_cycles = 0, first_done = -1, reads = 0, guard = 0, unk_exp = 0;
    int hold_left = hold;
    bit fin = 1'b0;
    logic [31:0] base = addr & 32'hFFFF_FFFC;
    for (int i = 0; i < cnt; i++) begin
      r.pc = base + 32'(4 * i);
      r.w  = mem_img[r.pc[7:2]];
      q.push_back(r);
      if (fmt_model(longint'(r.w)) == 7) unk_exp++;
    end
    out_ready = (hold == 0);
    pulse_start(addr, cnt);
    check({tag, "_unk_clear"}, 32'(unk_count), 32'd0);
    check({tag, "_busy_on"},   32'(busy),      32'd1);
    while (!fin) begin
      if (hold_left > 0) begin
        out_ready = 1'b0;
        if (out_valid && q.size() > 0) begin
          check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
          check_record({tag, "_hold"}, q[0]);
          hold_left--;
        end
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (mem_read) reads++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({tag, "_extra_record"}, 32'(got + 1), 32'(cnt));
        else begin
          r = q.pop_front();
          check_record($sformatf("%s_rec%0d", tag, got), r);
        end
        got++;
      end
      if (done) begin
        if (first_done < 0) first_done = guard;
        done_cycles++;
      end else if (done_cycles > 0) fin = 1'b1;
      guard++;
      if (guard > 3000) begin
        check({tag, "_timeout"}, 32'(guard), 32'd3000);
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    out_ready = 1'b1;
    check({tag, "_records"},   32'(got),         32'(cnt));
    check({tag, "_done_len"},  32'(done_cycles), 32'd1);
    check({tag, "_reads"},     32'(reads),       32'(cnt));
    check({tag, "_unk_count"}, 32'(unk_count),   32'(unk_exp));
    check({tag, "_busy_off"},  32'(busy),        32'd0);
    if (cnt == 0) check({tag, "_done_at"}, 32'(first_done), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    check({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_img[i] = 32'h0000_0013;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_read",  32'(mem_read),  32'd0);
    check("rst_unk",   32'(unk_count), 32'd0);
    check("rst_addr",  mem_addr,       32'd0);
    check("rst_pc",    out_pc,         32'd0);
    check("rst_type",  32'(out_type),  32'd0);

    // R / I / S sequence
    mem_img[10] = 32'h00A2_82B3;
    mem_img[11] = 32'h0043_0313;
    mem_img[12] = 32'h0062_A023;
    run_scan("basic", 32'h28, 3, 1'b0, 0);

    // Branch with negative offset and JAL
    mem_img[16] = 32'hFE00_08E3;
    mem_img[17] = 32'h0100_006F;
    run_scan("sb_uj", 32'h40, 2, 1'b0, 0);

    // Backpressure: first record held for 5 cycles
    run_scan("stall", 32'h40, 2, 1'b0, 5);

    // Empty scan and address wrap (bits[1:0] of start_addr ignored)
    run_scan("empty", 32'h28, 0, 1'b0, 0);
    mem_img[63] = 32'h1234_5037;
    mem_img[0]  = 32'h0000_0033;
    run_scan("wrap", 32'hFFFF_FFFF, 2, 1'b0, 0);

    // Unknown words, then a fresh start clears unk_count
    mem_img[20] = 32'hFFFF_FFFF;
    mem_img[21] = 32'hFFFF_FFFF;
    run_scan("unk", 32'h50, 2, 1'b0, 0);
    run_scan("unk_next", 32'h28, 1, 1'b0, 0);

    // Abort during WAIT
    pulse_start(32'h28, 3);
    check("abw_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abw_busy",  32'(busy),      32'd0);
    check("abw_valid", 32'(out_valid), 32'd0);
    expect_quiet("abw", 5);

    // Abort in OUT, racing a handshake
    out_ready = 1'b0;
    pulse_start(32'h28, 3);
    wait_valid("abo");
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abo_busy",  32'(busy),      32'd0);
    check("abo_valid", 32'(out_valid), 32'd0);
    expect_quiet("abo", 5);

    // Start and abort together in IDLE: start ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; count = 8'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);

    // Reset in OUT
    out_ready = 1'b0;
    pulse_start(32'h50, 2);
    wait_valid("rso");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rso_busy",  32'(busy),      32'd0);
    check("rso_valid", 32'(out_valid), 32'd0);
    check("rso_unk",   32'(unk_count), 32'd0);
    check("rso_pc",    out_pc,         32'd0);
    expect_quiet("rso", 4);
    run_scan("post_abort", 32'h28, 3, 1'b0, 0);

    // Random images with random backpressure
    for (int s = 0; s < 6; s++) begin
      logic [31:0] ops [10];
      logic [31:0] a;
      ops = '{32'h33, 32'h03, 32'h13, 32'h67, 32'h23, 32'h63, 32'h6F, 32'h37, 32'h17, 32'h7F};
      for (int i = 0; i < 64; i++) begin
        a = ops[$urandom_range(0, 9)];
        mem_img[i] = ($urandom() & 32'hFFFF_FF80) | a;
      end
      a = $urandom();
      run_scan($sformatf("rand%0d", s), a, $urandom_range(1, 12), 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
